// File: rtl/adder_pipe_dff.sv
// Pipelined WIDTH-bit add/subtract: carry chain split into STAGES registered chunks.
// Define ADDER_PIPE_SAT_EN to clamp the output sum to signed saturation on overflow.
module adder_pipe_dff #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned STAGES = 2
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             in_valid,
   input  logic             hold,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             overflow,
   output logic             out_valid
);

   localparam int unsigned CW   = WIDTH / STAGES;
   localparam int unsigned CWP  = CW + 1;
   localparam int unsigned LAST = STAGES - 1;

   // Per-stage operands (skewed), partial sum, chunk carry and valid.
   logic [WIDTH-1:0] a_q  [STAGES];
   logic [WIDTH-1:0] a_d  [STAGES];
   logic [WIDTH-1:0] bx_q [STAGES];
   logic [WIDTH-1:0] bx_d [STAGES];
   logic [WIDTH-1:0] s_q  [STAGES];
   logic [WIDTH-1:0] s_d  [STAGES];
   logic             c_q  [STAGES];
   logic             c_d  [STAGES];
   logic             v_q  [STAGES];
   logic             v_d  [STAGES];
   logic             ovf_q;
   logic             ovf_d;

   // Stage k adds chunk k using the carry registered by stage k-1.
   always_comb begin
      logic [WIDTH-1:0] op_a;
      logic [WIDTH-1:0] op_b;
      logic [WIDTH-1:0] part;
      logic [CW:0]      chunk;
      logic             ci;
      logic             vi;
      int unsigned      p;
      op_a  = '0;
      op_b  = '0;
      part  = '0;
      chunk = '0;
      ci    = 1'b0;
      vi    = 1'b0;
      p     = 0;
      ovf_d = ovf_q;
      for (int unsigned s = 0; s < STAGES; s++) begin
         a_d[s]  = a_q[s];
         bx_d[s] = bx_q[s];
         s_d[s]  = s_q[s];
         c_d[s]  = c_q[s];
         v_d[s]  = v_q[s];
      end
      if (!hold) begin
         for (int unsigned s = 0; s < STAGES; s++) begin
            p = (s == 0) ? 0 : s - 1;
            if (s == 0) begin
               op_a = a;
               op_b = b ^ {WIDTH{sub}};
               ci   = cin ^ sub;
               part = '0;
               vi   = in_valid;
            end else begin
               op_a = a_q[p];
               op_b = bx_q[p];
               ci   = c_q[p];
               part = s_q[p];
               vi   = v_q[p];
            end
            chunk = {1'b0, op_a[s*CW +: CW]} + {1'b0, op_b[s*CW +: CW]} + CWP'(ci);
            part[s*CW +: CW] = chunk[CW-1:0];
            a_d[s]  = op_a;
            bx_d[s] = op_b;
            s_d[s]  = part;
            c_d[s]  = chunk[CW];
            v_d[s]  = vi;
            if (s == LAST) begin
               ovf_d = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (part[WIDTH-1] != op_a[WIDTH-1]);
`ifdef ADDER_PIPE_SAT_EN
               // Clamp toward the sign of a; carry/overflow keep the raw result.
               if (ovf_d) begin
                  s_d[s] = {op_a[WIDTH-1], {(WIDTH-1){~op_a[WIDTH-1]}}};
               end
`endif
            end
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned s = 0; s < STAGES; s++) begin
            a_q[s]  <= '0;
            bx_q[s] <= '0;
            s_q[s]  <= '0;
            c_q[s]  <= 1'b0;
            v_q[s]  <= 1'b0;
         end
         ovf_q <= 1'b0;
      end else begin
         for (int unsigned s = 0; s < STAGES; s++) begin
            a_q[s]  <= a_d[s];
            bx_q[s] <= bx_d[s];
            s_q[s]  <= s_d[s];
            c_q[s]  <= c_d[s];
            v_q[s]  <= v_d[s];
         end
         ovf_q <= ovf_d;
      end
   end

   assign sum       = s_q[LAST];
   assign carry     = c_q[LAST];
   assign overflow  = ovf_q;
   assign out_valid = v_q[LAST];

endmodule
